// File: rtl/av2_frame_output_scanner_pkg.sv
// Shared plane codes, default plane sizes and scanner types.
package av2_frame_output_scanner_pkg;

  localparam int unsigned PLANE_W = 2;
  typedef logic [PLANE_W-1:0] plane_t;

  // Plane codes on the frame-buffer select bus and the output stream.
  localparam plane_t PLANE_Y = 2'd0;
  localparam plane_t PLANE_U = 2'd1;
  localparam plane_t PLANE_V = 2'd2;

  // Default word counts of the luma plane and of each chroma plane.
  localparam int unsigned Y_WORDS_DEFAULT = 256;
  localparam int unsigned C_WORDS_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_Y,
    SCAN_U,
    SCAN_V,
    DRAIN
  } state_t;

  // Side-band carried next to each data word through the output FIFO.
  typedef struct packed {
    logic   last;
    plane_t plane;
  } word_tag_t;

  localparam int unsigned TAG_W = $bits(word_tag_t);

  // Plane code read while scanning in a given state.
  function automatic plane_t state_plane(input state_t s);
    case (s)
      SCAN_U:  return PLANE_U;
      SCAN_V:  return PLANE_V;
      default: return PLANE_Y;
    endcase
  endfunction

  // State following the last word of a plane.
  function automatic state_t next_plane_state(input state_t s);
    case (s)
      SCAN_Y:  return SCAN_U;
      SCAN_U:  return SCAN_V;
      SCAN_V:  return DRAIN;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/av2_sync_fifo.sv
// Single-clock FIFO with occupancy count; head word reads as zero when empty.
module av2_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rd_fire = rd_en && !empty;
  assign wr_fire = wr_en && (!full || rd_fire);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; push and pop in one cycle leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/av2_frame_output_scanner.sv
// Reads the Y, U and V planes of one frame from the frame buffer and streams
// them out through a small credit-controlled FIFO.
module av2_frame_output_scanner
  import av2_frame_output_scanner_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned Y_WORDS    = Y_WORDS_DEFAULT,
  parameter int unsigned C_WORDS    = C_WORDS_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] fb_rd_addr,
  output logic                  fb_rd_en,
  output logic [1:0]            fb_rd_sel_plane,
  input  logic [DATA_WIDTH-1:0] fb_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            m_plane,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned MAX_WORDS = (Y_WORDS > C_WORDS) ? Y_WORDS : C_WORDS;
  localparam int unsigned CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned FCNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FIFO_W    = DATA_WIDTH + TAG_W;

  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(Y_WORDS - 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(C_WORDS - 1);

  state_t            state_q;
  state_t            state_d;
  state_t            scan_state;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  issue_addr;
  logic [CNT_W-1:0]  plane_last;
  plane_t            issue_plane;
  logic              issue;
  logic              issue_last;
  logic              start_go;
  logic              in_scan;
  logic              busy_d;
  logic              done_d;

  logic              rd_last_q;
  logic              ret_q;
  word_tag_t         ret_tag_q;

  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [FIFO_W-1:0] fifo_rd_data;
  word_tag_t         head_tag;
  logic              pop;
  logic              credit_ok;

  // A new read may issue only if every word already requested still fits in the FIFO.
  assign credit_ok = !fifo_full &&
                     ((32'(fifo_count) + 32'(fb_rd_en) + 32'(ret_q)) < FIFO_DEPTH);

  // Next-state, address counter and read-issue decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy;
    done_d      = 1'b0;
    issue       = 1'b0;
    issue_last  = 1'b0;
    issue_addr  = '0;
    issue_plane = PLANE_Y;
    plane_last  = '0;
    scan_state  = state_q;
    start_go    = (state_q == IDLE) && start;
    in_scan     = (state_q == SCAN_Y) || (state_q == SCAN_U) || (state_q == SCAN_V);

    // The first Y read goes out in the same edge that accepts start.
    if (start_go) begin
      scan_state = SCAN_Y;
      busy_d     = 1'b1;
    end

    issue      = start_go || (in_scan && credit_ok);
    plane_last = (scan_state == SCAN_Y) ? Y_LAST : C_LAST;

    if (issue) begin
      issue_addr  = start_go ? '0 : cnt_q;
      issue_plane = state_plane(scan_state);
      if (issue_addr == plane_last) begin
        cnt_d      = '0;
        state_d    = next_plane_state(scan_state);
        issue_last = (scan_state == SCAN_V);
      end else begin
        cnt_d   = issue_addr + CNT_W'(1);
        state_d = scan_state;
      end
    end

    // Frame ends on the edge that hands the final V word to the sink.
    if ((state_q == DRAIN) && pop && m_last) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  // FSM state, counter and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Read strobe and the tag pipeline that follows data back from the frame buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_rd_en        <= 1'b0;
      fb_rd_addr      <= '0;
      fb_rd_sel_plane <= '0;
      rd_last_q       <= 1'b0;
      ret_q           <= 1'b0;
      ret_tag_q       <= '0;
    end else begin
      fb_rd_en        <= issue;
      fb_rd_addr      <= ADDR_WIDTH'(issue_addr);
      fb_rd_sel_plane <= issue_plane;
      rd_last_q       <= issue_last;
      ret_q           <= fb_rd_en;
      ret_tag_q       <= '{last: rd_last_q, plane: fb_rd_sel_plane};
    end
  end

  av2_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ret_q),
    .wr_data ({ret_tag_q, fb_rd_data}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign m_valid  = !fifo_empty;
  assign pop      = m_valid && m_ready;
  assign head_tag = word_tag_t'(fifo_rd_data[FIFO_W-1:DATA_WIDTH]);
  assign m_data   = fifo_rd_data[DATA_WIDTH-1:0];
  assign m_plane  = head_tag.plane;
  assign m_last   = head_tag.last;

endmodule

// File: tb/tb_av2_frame_output_scanner.sv
// Scoreboard bench for the frame output scanner.
module tb_av2_frame_output_scanner;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 128;
  localparam int unsigned YW    = 256;
  localparam int unsigned CW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam int          FRAME = YW + 2 * CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] fb_rd_addr;
  logic          fb_rd_en;
  logic [1:0]    fb_rd_sel_plane;
  logic [DW-1:0] fb_rd_data = '0;
  logic [DW-1:0] m_data;
  logic [1:0]    m_plane;
  logic          m_last;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          busy;
  logic          done;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    plane;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   xfer_total = 0;
  int   rd_total = 0;
  int   salt = 0;
  int   frame_no = 0;
  int   ready_mode = 0;

  // monitor state
  int            occ = 0;
  logic          prev_en = 1'b0;
  logic          exp_done = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [1:0]    prev_plane = '0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] pending = '0;

  always #5 clk = ~clk;

  av2_frame_output_scanner #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .Y_WORDS    (YW),
    .C_WORDS    (CW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .fb_rd_addr      (fb_rd_addr),
    .fb_rd_en        (fb_rd_en),
    .fb_rd_sel_plane (fb_rd_sel_plane),
    .fb_rd_data      (fb_rd_data),
    .m_data          (m_data),
    .m_plane         (m_plane),
    .m_last          (m_last),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .busy            (busy),
    .done            (done)
  );

  // Frame-buffer content: address in the low bits, plane above, frame salt on top.
  function automatic logic [DW-1:0] mem_word(input int plane, input int addr, input int s);
    logic [DW-1:0] w;
    w = '0;
    w[15:0]       = 16'(addr);
    w[17:16]      = 2'(plane);
    w[DW-1:DW-32] = 32'(s);
    return w;
  endfunction

  // Expected stream of one whole frame: Y then U then V, ascending addresses.
  task automatic push_frame();
    exp_t e;
    for (int p = 0; p < 3; p++) begin
      int n;
      n = (p == 0) ? YW : CW;
      for (int a = 0; a < n; a++) begin
        e.data  = mem_word(p, a, salt);
        e.plane = 2'(p);
        e.last  = (p == 2) && (a == n - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, expv);
    end
  endtask

  task automatic check_vec(input string name, input logic [DW-1:0] got, input logic [DW-1:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Frame-buffer model: data for a read appears in the cycle after the strobe.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      fb_rd_data = pending;
      pending = fb_rd_en ? mem_word(int'(fb_rd_sel_plane), int'(fb_rd_addr), salt)
                         : {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Sink backpressure: 0 always ready, 1 random 50%, 2 stalled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops, stability, credit and occupancy checks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        occ        = 0;
        prev_en    = 1'b0;
        exp_done   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (exp_done || done) begin
          check_bit("done_pulse", done, exp_done);
          if (exp_done) check_bit("busy_low_at_done", busy, 1'b0);
        end
        exp_done = 1'b0;
        if (prev_stall) begin
          checks++;
          if (!m_valid || m_data !== prev_data || m_plane !== prev_plane || m_last !== prev_last) begin
            errors++;
            $display("FAIL stall_stability: got valid=%b data=%0h plane=%0d last=%b expected data=%0h plane=%0d last=%b",
                     m_valid, m_data, m_plane, m_last, prev_data, prev_plane, prev_last);
          end
        end
        check_bit("m_valid_vs_occupancy", m_valid, occ != 0);
        if (fb_rd_en) begin
          rd_total++;
          checks++;
          if (!(occ + int'(prev_en) < int'(DEPTH))) begin
            errors++;
            $display("FAIL credit_rule: got occupancy=%0d inflight=%0d required sum below %0d",
                     occ, prev_en, DEPTH);
          end
        end
        if (m_valid && m_ready) begin
          xfer_total++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL xfer_unexpected: got data=%0h plane=%0d expected no word", m_data, m_plane);
          end else begin
            e = exp_q.pop_front();
            if (m_data !== e.data || m_plane !== e.plane || m_last !== e.last) begin
              errors++;
              $display("FAIL xfer_word: got data=%0h plane=%0d last=%b expected data=%0h plane=%0d last=%b",
                       m_data, m_plane, m_last, e.data, e.plane, e.last);
            end
            if (e.last) exp_done = 1'b1;
          end
        end
        occ = occ + int'(prev_en) - int'(m_valid && m_ready);
        checks++;
        if (occ > int'(DEPTH) || occ < 0) begin
          errors++;
          $display("FAIL fifo_occupancy: got %0d required 0..%0d", occ, DEPTH);
        end
        prev_en    = fb_rd_en;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_plane = m_plane;
        prev_last  = m_last;
      end
    end
  end

  task automatic check_idle(input string tag);
    check_bit({tag, "_fb_rd_en"}, fb_rd_en, 1'b0);
    check_vec({tag, "_fb_rd_addr"}, DW'(fb_rd_addr), '0);
    check_vec({tag, "_fb_rd_sel_plane"}, DW'(fb_rd_sel_plane), '0);
    check_bit({tag, "_m_valid"}, m_valid, 1'b0);
    check_vec({tag, "_m_data"}, m_data, '0);
    check_vec({tag, "_m_plane"}, DW'(m_plane), '0);
    check_bit({tag, "_m_last"}, m_last, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, done, 1'b0);
  endtask

  // Start a frame, then check the startup timing up to the first valid word.
  task automatic start_frame();
    @(posedge clk);
    #1;
    salt = frame_no;
    frame_no++;
    push_frame();
    start = 1'b1;
    @(negedge clk);
    check_bit("busy_before_accept", busy, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_bit("busy_after_start", busy, 1'b1);
    check_bit("first_rd_en", fb_rd_en, 1'b1);
    check_vec("first_rd_addr", DW'(fb_rd_addr), '0);
    check_vec("first_rd_plane", DW'(fb_rd_sel_plane), '0);
    @(negedge clk);
    check_bit("m_valid_two_after_start", m_valid, 1'b0);
    check_bit("second_rd_en", fb_rd_en, 1'b1);
    check_vec("second_rd_addr", DW'(fb_rd_addr), DW'(1));
    @(negedge clk);
    check_bit("m_valid_three_after_start", m_valid, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 5000);
    check_bit({tag, "_done_reached"}, done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int cyc;
    int nval;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // Full speed frame with word i = i in the Y plane; the stream is unbroken.
    ready_mode = 0;
    base = xfer_total;
    start_frame();
    cyc  = 0;
    nval = 0;
    while (cyc < 2000) begin
      if (m_valid && m_ready) nval++;
      if (m_valid && m_ready && m_last) break;
      @(negedge clk);
      cyc++;
    end
    check_int("contiguous_cycles", cyc, FRAME - 1);
    check_int("contiguous_words", nval, FRAME);
    wait_done("full_speed");
    check_int("full_speed_words", xfer_total - base, FRAME);
    check_int("full_speed_queue_empty", exp_q.size(), 0);

    // Sink stalled: only as many reads as the FIFO can hold.
    ready_mode = 2;
    base = rd_total;
    start_frame();
    repeat (17) @(negedge clk);
    check_int("stalled_reads", rd_total - base, int'(DEPTH));
    check_bit("stalled_m_valid", m_valid, 1'b1);
    check_vec("stalled_head_data", m_data, mem_word(0, 0, salt));
    check_vec("stalled_head_plane", DW'(m_plane), '0);
    ready_mode = 0;
    wait_done("stall_release");
    check_int("stall_queue_empty", exp_q.size(), 0);

    // Random backpressure.
    ready_mode = 1;
    base = xfer_total;
    start_frame();
    wait_done("random_ready");
    check_int("random_words", xfer_total - base, FRAME);
    check_int("random_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a frame, then a clean frame.
    ready_mode = 1;
    start_frame();
    base = xfer_total;
    cyc = 0;
    while (xfer_total - base < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_bit("reached_transfer_100", (xfer_total - base) >= 100, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("mid_frame_reset");
    ready_mode = 0;
    base = xfer_total;
    start_frame();
    wait_done("after_reset");
    check_int("after_reset_words", xfer_total - base, FRAME);
    check_int("after_reset_queue_empty", exp_q.size(), 0);

    // Start while busy is ignored; start right after done is accepted.
    ready_mode = 1;
    base = xfer_total;
    start_frame();
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start");
    check_int("busy_start_words", xfer_total - base, FRAME);
    check_int("busy_start_queue_empty", exp_q.size(), 0);
    base = xfer_total;
    start_frame();
    wait_done("back_to_back");
    check_int("back_to_back_words", xfer_total - base, FRAME);
    check_int("back_to_back_queue_empty", exp_q.size(), 0);
    repeat (10) @(negedge clk);
    check_idle("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
